// File: rtl/ram_stream_reader_pkg.sv
// Shared types for the RAM block stream reader: FSM states and the
// {valid,last} tag that travels alongside each outstanding RAM read.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, last: 1'b0};

endpackage

// File: rtl/stream_fifo_fwft.sv
// First-word-fall-through return buffer. Data written in cycle N is
// visible on dout with valid=1 in cycle N+1. Storage is reset so the
// output bus reads zero out of reset. DEPTH must be a power of 2.
module stream_fifo_fwft #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        pop_ok;

    // Pointer, storage and occupancy update; push+pop together keeps count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && (count_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Buffer state registers, cleared on reset so no stale word survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Reads len words starting at base_addr through a fixed-latency RAM read
// port and re-emits them as a valid/ready stream with m_last on the final
// beat. Reads are only issued while the words already in flight plus the
// words parked in the return buffer leave room, so a stalled consumer can
// never cause a returning word to be dropped.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 72,
    parameter int ADDR_WIDTH = 13,
    parameter int RD_LATENCY = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [ADDR_WIDTH:0]     issued_q, issued_d;
    logic [CW-1:0]           inflight_q, inflight_d;
    logic                    done_q, done_d;
    tag_t [RD_LATENCY-1:0]   pipe_q, pipe_d;

    logic [CW-1:0]           fifo_count;
    logic [ADDR_WIDTH:0]     issued_inc;
    logic [CW:0]             occupancy;
    logic                    credit_ok;
    logic                    start_ok;
    logic                    last_pop;
    tag_t                    ret_tag;

    assign issued_inc = issued_q + (ADDR_WIDTH + 1)'(1);
    // Registered counts only: a pop in this cycle does not free a slot yet.
    assign occupancy  = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign credit_ok  = (occupancy < DEPTH_C);
    assign start_ok   = start && (state_q == ST_IDLE);
    assign last_pop   = m_valid && m_ready && m_last;
    assign ret_tag    = pipe_q[RD_LATENCY-1];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a zero-length start never leaves IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && (len != '0)) state_d = ST_RUN;
            ST_RUN:   if (rd_en && (issued_inc == len_q)) state_d = ST_DRAIN;
            ST_DRAIN: if (last_pop) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: read issue gated by remaining words and buffer credit.
    always_comb begin
        busy    = (state_q != ST_IDLE);
        rd_en   = (state_q == ST_RUN) && (issued_q < len_q) && credit_ok;
        rd_addr = base_q + issued_q[ADDR_WIDTH-1:0];
    end

    // Transfer bookkeeping, in-flight count and return tag pipe next values.
    always_comb begin
        base_d     = base_q;
        len_d      = len_q;
        issued_d   = issued_q;
        inflight_d = inflight_q;
        done_d     = 1'b0;
        if (start_ok && (len != '0)) begin
            base_d   = base_addr;
            len_d    = len;
            issued_d = '0;
        end else if (rd_en) begin
            issued_d = issued_inc;
        end
        if (start_ok && (len == '0)) begin
            done_d = 1'b1;
        end
        if ((state_q == ST_DRAIN) && last_pop) begin
            done_d = 1'b1;
        end
        if (rd_en && !ret_tag.valid) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!rd_en && ret_tag.valid) begin
            inflight_d = inflight_q - CW'(1);
        end
        pipe_d    = pipe_q;
        pipe_d[0] = '{valid: rd_en, last: rd_en && (issued_inc == len_q)};
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Datapath registers; reset drops every tag still in the return pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= '0;
            done_q     <= 1'b0;
            pipe_q     <= {RD_LATENCY{TAG_NONE}};
        end else begin
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            pipe_q     <= pipe_d;
        end
    end

    assign done = done_q;

    // Return buffer: the word leaving the tag pipe is written with its last flag.
    stream_fifo_fwft #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ret_tag.valid),
        .din   ({ret_tag.last, rd_data}),
        .pop   (m_valid && m_ready),
        .dout  ({m_last, m_data}),
        .valid (m_valid),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural 4-cycle RAM
// holding mem[a] = a.
module tb_ram_stream_reader;

    localparam int DW = 72;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy, done, rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          m_valid, m_last, m_ready;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    ram_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready)
    );

    // RAM model: data appears 4 cycles after rd_en; idle slots carry all-ones.
    logic [DW-1:0] rp [4];
    always @(posedge clk) begin
        rp[0] <= rd_en ? DW'(rd_addr) : {DW{1'b1}};
        rp[1] <= rp[0];
        rp[2] <= rp[1];
        rp[3] <= rp[2];
    end
    assign rd_data = rp[3];

    int errors = 0;
    int checks = 0;
    int cyc_n = 0;
    int t0, first_rd, first_vld, first_hs, last_hs, done_at, hs_cnt, rd_cnt, done_cnt;
    bit busy_seen, stall_seen, prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] rdlog[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        first_rd = -1; first_vld = -1; first_hs = -1; last_hs = -1; done_at = -1;
        hs_cnt = 0; rd_cnt = 0; done_cnt = 0;
        busy_seen = 0; stall_seen = 0; prev_stall = 0;
        rdlog.delete();
    endtask

    // Observe the current cycle, then advance to 1 time unit after the next edge.
    task automatic cyc();
        int rel;
        int occ;
        logic [DW-1:0] e;
        rel = cyc_n - t0;
        occ = int'(dut.inflight_q) + int'(dut.u_fifo.count_q);
        if (rst_n) begin
            chk("occupancy_le_depth", DW'(occ <= 8), DW'(1));
            if (occ >= 8) begin
                stall_seen = 1;
                chk("rd_en_no_credit", DW'(rd_en), DW'(0));
            end
            if (prev_stall) begin
                chk("hold_valid", DW'(m_valid), DW'(1));
                chk("hold_data", m_data, prev_data);
                chk("hold_last", DW'(m_last), DW'(prev_last));
            end
            if (rd_en) begin
                if (first_rd < 0) first_rd = rel;
                rdlog.push_back(rd_addr);
                rd_cnt++;
            end
            if (busy) busy_seen = 1;
            if (m_valid && first_vld < 0) first_vld = rel;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = rel;
                chk("busy_low_at_done", DW'(busy), DW'(0));
            end
            if (m_valid && m_ready) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = rel;
                if (m_last) last_hs = rel;
                chk("beat_expected", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e);
                    chk("beat_last", DW'(m_last), DW'(exp_q.size() == 0));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 0;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // mode 0: always ready; mode 1: random ready with a 20-cycle stall.
    task automatic set_ready(input int mode, input int rel);
        if (mode == 0) m_ready = 1'b1;
        else if (rel >= 20 && rel < 40) m_ready = 1'b0;
        else m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic launch(input logic [AW-1:0] b, input logic [AW:0] l, input int mode);
        logic [AW-1:0] a;
        clear_stats();
        exp_q.delete();
        t0 = cyc_n;
        for (int i = 0; i < int'(l); i++) begin
            a = b + AW'(i);
            exp_q.push_back(DW'(a));
        end
        start     = 1'b1;
        base_addr = b;
        len       = l;
        set_ready(mode, 0);
        cyc();
        start = 1'b0;
    endtask

    task automatic run_xfer(input logic [AW-1:0] b, input logic [AW:0] l, input int mode, input int limit);
        launch(b, l, mode);
        while (done_at < 0 && (cyc_n - t0) < limit) begin
            set_ready(mode, cyc_n - t0);
            cyc();
        end
        chk("done_seen", DW'(done_at >= 0), DW'(1));
        chk("no_loss", DW'(exp_q.size()), DW'(0));
        chk("beat_count", DW'(hs_cnt), DW'(l));
        chk("read_count", DW'(rd_cnt), DW'(l));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
        t0 = 0;
        clear_stats();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_rd_en", DW'(rd_en), DW'(0));
        chk("rst_rd_addr", DW'(rd_addr), DW'(0));
        chk("rst_m_valid", DW'(m_valid), DW'(0));
        chk("rst_m_last", DW'(m_last), DW'(0));
        chk("rst_m_data", m_data, DW'(0));
        rst_n = 1'b1;
        cyc(); cyc();

        // 1: basic 5-word read, always ready
        run_xfer(13'h0010, 14'd5, 0, 100);
        chk("t1_first_rd", DW'(first_rd), DW'(1));
        chk("t1_first_valid", DW'(first_vld), DW'(6));
        chk("t1_last_hs", DW'(last_hs), DW'(10));
        chk("t1_done_at", DW'(done_at), DW'(11));
        cyc(); cyc();

        // 2: zero length is a no-op with a done pulse
        run_xfer(13'h0020, 14'd0, 0, 20);
        cyc(); cyc(); cyc();
        chk("t2_done_at", DW'(done_at), DW'(1));
        chk("t2_done_pulses", DW'(done_cnt), DW'(1));
        chk("t2_no_rd_en", DW'(rd_cnt), DW'(0));
        chk("t2_busy_seen", DW'(busy_seen), DW'(0));

        // 3: address wrap at top of RAM
        run_xfer(13'h1FFE, 14'd4, 0, 100);
        chk("t3_nreads", DW'(rdlog.size()), DW'(4));
        if (rdlog.size() == 4) begin
            chk("t3_addr0", DW'(rdlog[0]), DW'(13'h1FFE));
            chk("t3_addr1", DW'(rdlog[1]), DW'(13'h1FFF));
            chk("t3_addr2", DW'(rdlog[2]), DW'(13'h0000));
            chk("t3_addr3", DW'(rdlog[3]), DW'(13'h0001));
        end
        cyc();

        // 4: 64 words under random backpressure with a long stall
        run_xfer(13'h0100, 14'd64, 1, 2000);
        chk("t4_credit_exhausted", DW'(stall_seen), DW'(1));
        m_ready = 1'b1;
        cyc();

        // 5: 32 words back to back with no bubbles
        run_xfer(13'h0200, 14'd32, 0, 200);
        chk("t5_no_bubble", DW'(last_hs - first_hs), DW'(31));
        cyc();

        // 6: reset after 10 reads, then a fresh 3-word transfer
        launch(13'h0300, 14'd64, 0);
        while (rd_cnt < 10 && (cyc_n - t0) < 100) cyc();
        chk("t6_ten_reads", DW'(rd_cnt), DW'(10));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", DW'(busy), DW'(0));
        chk("t6_rst_rd_en", DW'(rd_en), DW'(0));
        chk("t6_rst_m_valid", DW'(m_valid), DW'(0));
        chk("t6_rst_m_data", m_data, DW'(0));
        chk("t6_rst_m_last", DW'(m_last), DW'(0));
        chk("t6_rst_done", DW'(done), DW'(0));
        exp_q.delete();
        cyc(); cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t6_no_stale_valid", DW'(m_valid), DW'(0));
            chk("t6_no_done", DW'(done), DW'(0));
            cyc();
        end
        run_xfer(13'h0040, 14'd3, 0, 100);
        chk("t6_first_valid", DW'(first_vld), DW'(6));
        for (int i = 0; i < 6; i++) begin
            chk("t6_quiet_after", DW'(m_valid), DW'(0));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
